// File: rtl/video_pattern_gen.sv
// Raster timing generator with selectable test patterns driving the HDMI/TMDS transmitter RGB inputs.
// Optional macro PATTERN_SCROLL_EN: per-frame counter that scrolls the colour bars and tints the gradient.
module video_pattern_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int SYNC_POL = 0
) (
    input  logic        clk_low,
    input  logic        reset,
    input  logic [1:0]  pattern_sel,
    output logic        hsync,
    output logic        vsync,
    output logic        de,
    output logic [7:0]  red,
    output logic [7:0]  green,
    output logic [7:0]  blue,
    output logic [11:0] x,
    output logic [11:0] y,
    output logic        frame_start
);
    localparam logic [11:0] H_ACT_C      = 12'(H_ACTIVE);
    localparam logic [11:0] H_SYNC_ON_C  = 12'(H_ACTIVE + H_FP);
    localparam logic [11:0] H_SYNC_OFF_C = 12'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [11:0] H_LAST_C     = 12'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
    localparam logic [11:0] V_ACT_C      = 12'(V_ACTIVE);
    localparam logic [11:0] V_SYNC_ON_C  = 12'(V_ACTIVE + V_FP);
    localparam logic [11:0] V_SYNC_OFF_C = 12'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [11:0] V_LAST_C     = 12'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
    localparam logic [11:0] BAR_W_C      = 12'(H_ACTIVE / 8);
    localparam logic        SYNC_ON_C    = 1'(SYNC_POL);

    typedef struct packed {
        logic [3:0]  idx;
        logic [11:0] px;
        logic [11:0] pos;
    } bar_t;

    // Steps the bar tracker by one column; pos wraps at the active width so scrolled bars repeat.
    function automatic bar_t bar_adv(input bar_t s);
        bar_t n;
        n = s;
        if (s.pos == H_ACT_C - 12'd1) begin
            n = '0;
        end else if (s.px == BAR_W_C - 12'd1) begin
            n.idx = s.idx + 4'd1;
            n.px  = 12'd0;
            n.pos = s.pos + 12'd1;
        end else begin
            n.px  = s.px + 12'd1;
            n.pos = s.pos + 12'd1;
        end
        return n;
    endfunction

    function automatic logic [23:0] bar_colour(input logic [3:0] idx);
        logic [23:0] c;
        case (idx)
            4'd0:    c = 24'hFFFFFF;
            4'd1:    c = 24'hFFFF00;
            4'd2:    c = 24'h00FFFF;
            4'd3:    c = 24'h00FF00;
            4'd4:    c = 24'hFF00FF;
            4'd5:    c = 24'hFF0000;
            4'd6:    c = 24'h0000FF;
            default: c = 24'h000000;
        endcase
        return c;
    endfunction

    logic [11:0] r_h_cnt;
    logic [11:0] r_v_cnt;
    logic [1:0]  r_pat;
    bar_t        r_bar;

    logic        w_h_last;
    logic        w_v_last;
    logic        w_first;
    logic        w_active;
    logic        w_hs_on;
    logic        w_vs_on;
    logic [1:0]  w_pat;
    logic [7:0]  w_fc;
    bar_t        w_line_init;
    logic [23:0] w_rgb;

    assign w_h_last = (r_h_cnt == H_LAST_C);
    assign w_v_last = (r_v_cnt == V_LAST_C);
    assign w_first  = (r_h_cnt == 12'd0) && (r_v_cnt == 12'd0);
    assign w_active = (r_h_cnt < H_ACT_C) && (r_v_cnt < V_ACT_C);
    assign w_hs_on  = (r_h_cnt >= H_SYNC_ON_C) && (r_h_cnt < H_SYNC_OFF_C);
    assign w_vs_on  = (r_v_cnt >= V_SYNC_ON_C) && (r_v_cnt < V_SYNC_OFF_C);
    // The pixel at (0,0) already uses the newly sampled selection, so a frame never mixes patterns.
    assign w_pat    = w_first ? pattern_sel : r_pat;

`ifdef PATTERN_SCROLL_EN
    logic [7:0] r_fc;
    bar_t       r_start;
    bar_t       w_start_nxt;

    // Bar tracker start point for the next frame: one column further, back to zero when the counter wraps.
    always_comb begin
        w_start_nxt = '0;
        if (r_fc == 8'hFF) begin
            w_start_nxt = '0;
        end else begin
            w_start_nxt = bar_adv(r_start);
        end
    end

    // Frame counter and scroll origin advance together at the last pixel of each frame.
    always_ff @(posedge clk_low or posedge reset) begin
        if (reset) begin
            r_fc    <= 8'd0;
            r_start <= '0;
        end else if (w_h_last && w_v_last) begin
            r_fc    <= r_fc + 8'd1;
            r_start <= w_start_nxt;
        end
    end

    assign w_fc        = r_fc;
    assign w_line_init = w_v_last ? w_start_nxt : r_start;
`else
    assign w_fc        = 8'h00;
    assign w_line_init = '0;
`endif

    // Horizontal and vertical raster counters.
    always_ff @(posedge clk_low or posedge reset) begin
        if (reset) begin
            r_h_cnt <= 12'd0;
            r_v_cnt <= 12'd0;
        end else if (w_h_last) begin
            r_h_cnt <= 12'd0;
            r_v_cnt <= w_v_last ? 12'd0 : r_v_cnt + 12'd1;
        end else begin
            r_h_cnt <= r_h_cnt + 12'd1;
        end
    end

    // Pattern selection latched once per frame.
    always_ff @(posedge clk_low or posedge reset) begin
        if (reset) begin
            r_pat <= 2'd0;
        end else if (w_first) begin
            r_pat <= pattern_sel;
        end
    end

    // Bar tracker: reloaded at every line start, stepped across the active columns (no divider).
    always_ff @(posedge clk_low or posedge reset) begin
        if (reset) begin
            r_bar <= '0;
        end else if (w_h_last) begin
            r_bar <= w_line_init;
        end else if (r_h_cnt < H_ACT_C) begin
            r_bar <= bar_adv(r_bar);
        end
    end

    // Colour for the pixel described by the current counter state.
    always_comb begin
        w_rgb = 24'h000000;
        case (w_pat)
            2'd0: w_rgb = 24'h000000;
            2'd1: w_rgb = bar_colour(r_bar.idx);
            2'd2: begin
                if ((r_h_cnt[4:0] == 5'd0) || (r_v_cnt[4:0] == 5'd0)) begin
                    w_rgb = 24'hFFFFFF;
                end else begin
                    w_rgb = 24'h000000;
                end
            end
            2'd3: w_rgb = {r_h_cnt[7:0], r_v_cnt[7:0], r_h_cnt[7:0] ^ r_v_cnt[7:0] ^ w_fc};
            default: w_rgb = 24'h000000;
        endcase
    end

    // Output register stage: every output lags its counter state by exactly one cycle.
    always_ff @(posedge clk_low or posedge reset) begin
        if (reset) begin
            hsync              <= ~SYNC_ON_C;
            vsync              <= ~SYNC_ON_C;
            de                 <= 1'b0;
            frame_start        <= 1'b0;
            {red, green, blue} <= 24'h000000;
            x                  <= 12'd0;
            y                  <= 12'd0;
        end else begin
            hsync              <= w_hs_on ? SYNC_ON_C : ~SYNC_ON_C;
            vsync              <= w_vs_on ? SYNC_ON_C : ~SYNC_ON_C;
            de                 <= w_active;
            frame_start        <= w_first;
            {red, green, blue} <= w_active ? w_rgb : 24'h000000;
            x                  <= w_active ? r_h_cnt : 12'd0;
            y                  <= w_active ? r_v_cnt : 12'd0;
        end
    end

endmodule

// File: tb/tb_video_pattern_gen.sv
// Self-checking bench for video_pattern_gen on a reduced raster, compared against an arithmetic pixel model.
module tb_video_pattern_gen;
    localparam int HA = 100, HFP = 5, HS = 10, HBP = 5;
    localparam int VA = 40, VFP = 3, VS = 2, VBP = 4;
    localparam int SP = 0;
    localparam int HT = HA + HFP + HS + HBP;
    localparam int VT = VA + VFP + VS + VBP;
    localparam int FRAME = HT * VT;
    localparam int BW = HA / 8;
    localparam logic [51:0] RST_VEC = {~1'(SP), ~1'(SP), 1'b0, 24'h0, 12'h0, 12'h0, 1'b0};

    logic        clk_low = 1'b0;
    logic        reset = 1'b1;
    logic [1:0]  pattern_sel = 2'd0;
    logic        hsync, vsync, de, frame_start;
    logic [7:0]  red, green, blue;
    logic [11:0] x, y;
    logic [51:0] dut_vec;
    logic [51:0] exp_vec;

    int total = 0;
    int bad = 0;
    int m_h = 0, m_v = 0, m_fc = 0;
    logic [1:0] m_pat = 2'd0;

    video_pattern_gen #(
        .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP), .SYNC_POL(SP)
    ) dut (
        .clk_low(clk_low), .reset(reset), .pattern_sel(pattern_sel),
        .hsync(hsync), .vsync(vsync), .de(de),
        .red(red), .green(green), .blue(blue),
        .x(x), .y(y), .frame_start(frame_start)
    );

    assign dut_vec = {hsync, vsync, de, red, green, blue, x, y, frame_start};

    always #5 clk_low = ~clk_low;

    function automatic logic [23:0] bar_rgb(input int i);
        case (i)
            0: return 24'hFFFFFF;
            1: return 24'hFFFF00;
            2: return 24'h00FFFF;
            3: return 24'h00FF00;
            4: return 24'hFF00FF;
            5: return 24'hFF0000;
            6: return 24'h0000FF;
            default: return 24'h000000;
        endcase
    endfunction

    function automatic logic [51:0] model_pixel(input int h, input int v, input logic [1:0] pat, input int fc);
        logic hs, vs, act, fs;
        logic [23:0] rgb;
        int xx, yy;
        hs  = (h >= HA + HFP && h < HA + HFP + HS) ? 1'(SP) : ~1'(SP);
        vs  = (v >= VA + VFP && v < VA + VFP + VS) ? 1'(SP) : ~1'(SP);
        act = (h < HA) && (v < VA);
        fs  = (h == 0) && (v == 0);
        rgb = 24'h0;
        xx = 0;
        yy = 0;
        if (act) begin
            xx = h;
            yy = v;
            case (pat)
                2'd1: rgb = bar_rgb(((h + fc) % HA) / BW);
                2'd2: rgb = (h % 32 == 0 || v % 32 == 0) ? 24'hFFFFFF : 24'h000000;
                2'd3: rgb = {8'(h % 256), 8'(v % 256), 8'((h ^ v ^ fc) % 256)};
                default: rgb = 24'h0;
            endcase
        end
        return {hs, vs, act, rgb, 12'(xx), 12'(yy), fs};
    endfunction

    task automatic model_reset();
        m_h = 0;
        m_v = 0;
        m_fc = 0;
        m_pat = 2'd0;
    endtask

    // Predicts the pixel for the current raster position, clocks once, then advances the model.
    task automatic clk_step();
        logic [1:0] pat_now;
        pat_now = (m_h == 0 && m_v == 0) ? pattern_sel : m_pat;
        exp_vec = model_pixel(m_h, m_v, pat_now, m_fc);
        m_pat = pat_now;
        @(posedge clk_low);
        #1;
        if (m_h == HT - 1) begin
            m_h = 0;
            if (m_v == VT - 1) begin
                m_v = 0;
`ifdef PATTERN_SCROLL_EN
                m_fc = (m_fc + 1) % 256;
`endif
            end else begin
                m_v++;
            end
        end else begin
            m_h++;
        end
    endtask

    task automatic sync_frame();
        while (!(m_h == 0 && m_v == 0)) clk_step();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk_low);
        #1;
        total++;
        if (dut_vec !== RST_VEC) begin
            bad++;
            $display("FAIL reset_values got=%h exp=%h", dut_vec, RST_VEC);
        end
        @(negedge clk_low);
        reset = 1'b0;
        model_reset();
        clk_step();
        total++;
        if (dut_vec !== exp_vec) begin
            bad++;
            $display("FAIL first_pixel got=%h exp=%h", dut_vec, exp_vec);
        end
        total++;
        if (frame_start !== 1'b1 || de !== 1'b1) begin
            bad++;
            $display("FAIL first_pulse frame_start=%b de=%b exp 1 1", frame_start, de);
        end
    endtask

    task automatic test_timing();
        int hs_low = 0, de_hi = 0, vs_low = 0, fs_cnt = 0, last_fs = -1;
        int h, v;
        pattern_sel = 2'($urandom_range(0, 3));
        for (int i = 0; i < 2 * FRAME; i++) begin
            if ($urandom_range(0, 99) == 0) pattern_sel = 2'($urandom_range(0, 3));
            h = m_h;
            v = m_v;
            clk_step();
            total++;
            if (dut_vec !== exp_vec) begin
                bad++;
                $display("FAIL timing_model h=%0d v=%0d got=%h exp=%h", h, v, dut_vec, exp_vec);
            end
            if (hsync === 1'b0) hs_low++;
            if (vsync === 1'b0) vs_low++;
            if (de === 1'b1) de_hi++;
            if (frame_start === 1'b1) begin
                fs_cnt++;
                if (last_fs >= 0) begin
                    total++;
                    if (i - last_fs !== FRAME) begin
                        bad++;
                        $display("FAIL frame_period got=%0d exp=%0d", i - last_fs, FRAME);
                    end
                end
                last_fs = i;
            end
        end
        total++;
        if (hs_low !== 2 * VT * HS) begin
            bad++;
            $display("FAIL hsync_low got=%0d exp=%0d", hs_low, 2 * VT * HS);
        end
        total++;
        if (de_hi !== 2 * VA * HA) begin
            bad++;
            $display("FAIL de_high got=%0d exp=%0d", de_hi, 2 * VA * HA);
        end
        total++;
        if (vs_low !== 2 * VS * HT) begin
            bad++;
            $display("FAIL vsync_low got=%0d exp=%0d", vs_low, 2 * VS * HT);
        end
        total++;
        if (fs_cnt !== 2) begin
            bad++;
            $display("FAIL frame_start_count got=%0d exp=2", fs_cnt);
        end
    endtask

    task automatic test_random();
        int h, v;
        for (int i = 0; i < FRAME - 1; i++) begin
            if ($urandom_range(0, 49) == 0) pattern_sel = 2'($urandom_range(0, 3));
            h = m_h;
            v = m_v;
            clk_step();
            total++;
            if (dut_vec !== exp_vec) begin
                bad++;
                $display("FAIL random_model h=%0d v=%0d got=%h exp=%h", h, v, dut_vec, exp_vec);
            end
        end
    endtask

    task automatic test_bars();
        int h, v;
        logic [23:0] want;
        logic spot;
        pattern_sel = 2'd1;
        sync_frame();
        for (int i = 0; i < FRAME; i++) begin
            h = m_h;
            v = m_v;
            clk_step();
            total++;
            if (dut_vec !== exp_vec) begin
                bad++;
                $display("FAIL bars_model h=%0d v=%0d got=%h exp=%h", h, v, dut_vec, exp_vec);
            end
            if (de === 1'b0) begin
                total++;
                if ({red, green, blue, x, y} !== 48'h0) begin
                    bad++;
                    $display("FAIL blank_zero h=%0d v=%0d got=%h exp=0", h, v, {red, green, blue, x, y});
                end
            end
`ifndef PATTERN_SCROLL_EN
            spot = 1'b1;
            case (h)
                0, BW - 1:       want = 24'hFFFFFF;
                BW:              want = 24'hFFFF00;
                7 * BW - 1:      want = 24'h0000FF;
                7 * BW, HA - 1:  want = 24'h000000;
                default: begin
                    spot = 1'b0;
                    want = 24'h000000;
                end
            endcase
            if (v == 10 && spot) begin
                total++;
                if ({red, green, blue} !== want) begin
                    bad++;
                    $display("FAIL bar_spot x=%0d got=%h exp=%h", h, {red, green, blue}, want);
                end
            end
`endif
        end
    endtask

    task automatic test_gradient();
        int h, v;
        pattern_sel = 2'd3;
        sync_frame();
        for (int i = 0; i < FRAME; i++) begin
            h = m_h;
            v = m_v;
            clk_step();
            total++;
            if (dut_vec !== exp_vec) begin
                bad++;
                $display("FAIL grad_model h=%0d v=%0d got=%h exp=%h", h, v, dut_vec, exp_vec);
            end
`ifndef PATTERN_SCROLL_EN
            if (h == 5 && v == 3) begin
                total++;
                if ({red, green, blue} !== 24'h050306) begin
                    bad++;
                    $display("FAIL grad_5_3 got=%h exp=050306", {red, green, blue});
                end
            end
            if (h == 99 && v == 39) begin
                total++;
                if ({red, green, blue} !== 24'h632744) begin
                    bad++;
                    $display("FAIL grad_99_39 got=%h exp=632744", {red, green, blue});
                end
            end
`endif
        end
    endtask

    task automatic test_pattern_switch();
        int h, v;
        pattern_sel = 2'd1;
        sync_frame();
        for (int i = 0; i < FRAME + 2 * HT; i++) begin
            if (i == 20 * HT) pattern_sel = 2'd2;
            h = m_h;
            v = m_v;
            clk_step();
            total++;
            if (dut_vec !== exp_vec) begin
                bad++;
                $display("FAIL switch_model h=%0d v=%0d got=%h exp=%h", h, v, dut_vec, exp_vec);
            end
`ifndef PATTERN_SCROLL_EN
            if (i < FRAME && v == 30 && h == BW) begin
                total++;
                if ({red, green, blue} !== 24'hFFFF00) begin
                    bad++;
                    $display("FAIL switch_keeps_bars got=%h exp=ffff00", {red, green, blue});
                end
            end
`endif
            if (i >= FRAME && v == 0 && h == 32) begin
                total++;
                if ({red, green, blue} !== 24'hFFFFFF) begin
                    bad++;
                    $display("FAIL grid_32_0 got=%h exp=ffffff", {red, green, blue});
                end
            end
            if (i >= FRAME && v == 1 && h == 33) begin
                total++;
                if ({red, green, blue} !== 24'h000000) begin
                    bad++;
                    $display("FAIL grid_33_1 got=%h exp=000000", {red, green, blue});
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        pattern_sel = 2'd3;
        while (!(m_h == 30 && m_v == 20)) clk_step();
        total++;
        if (de !== 1'b1) begin
            bad++;
            $display("FAIL pre_reset_de got=%b exp=1", de);
        end
        #2;
        reset = 1'b1;
        #1;
        total++;
        if (dut_vec !== RST_VEC) begin
            bad++;
            $display("FAIL async_reset got=%h exp=%h", dut_vec, RST_VEC);
        end
        @(posedge clk_low);
        @(negedge clk_low);
        reset = 1'b0;
        model_reset();
        clk_step();
        total++;
        if (dut_vec !== exp_vec || frame_start !== 1'b1) begin
            bad++;
            $display("FAIL restart_pixel got=%h exp=%h", dut_vec, exp_vec);
        end
    endtask

    initial begin
        test_reset();
        test_timing();
        test_random();
        test_bars();
        test_gradient();
        test_pattern_switch();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/video_pattern_gen.md
Name: video_pattern_gen

Overview:
- Pixel-rate source that sits directly upstream of the HDMI/TMDS transceiver and drives its red/green/blue inputs.
- Runs in the transceiver's low-speed pixel clock domain (clk_low).
- Generates standard raster timing (hsync, vsync, data enable) plus a selectable test pattern, so the HDMI link can be brought up and checked without a camera pipeline.

Parameters:
- H_ACTIVE, 640, active pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, active lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vsync width (lines)
- V_BP, 33, vertical back porch (lines)
- SYNC_POL, 0, active level of hsync/vsync (0 = active-low)

Ports:
- clk_low  in  1  pixel clock; all logic on its rising edge
- reset  in  1  asynchronous, active-high reset
- pattern_sel  in  2  0 black, 1 colour bars, 2 grid, 3 gradient
- hsync  out  1  horizontal sync, level per SYNC_POL
- vsync  out  1  vertical sync, level per SYNC_POL
- de  out  1  data enable, high during active pixels
- red  out  8  pixel red
- green  out  8  pixel green
- blue  out  8  pixel blue
- x  out  12  active-area column of the current output pixel (0 when de=0)
- y  out  12  active-area row of the current output pixel (0 when de=0)
- frame_start  out  1  one-cycle pulse coincident with pixel (0,0)

Behaviour:
- Clock and reset: one clock (clk_low). Reset is asynchronous and active-high.
- Reset values:
  - h_cnt = 0, v_cnt = 0
  - de = 0, frame_start = 0
  - red = green = blue = 0, x = y = 0
  - hsync = vsync = ~SYNC_POL (inactive)
  - Latched pattern = 0
- Counters:
  - H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL likewise from the V_* parameters.
  - h_cnt counts 0..H_TOTAL-1, then wraps to 0.
  - v_cnt increments when h_cnt wraps and counts 0..V_TOTAL-1, then wraps to 0.
  - Both counters are 12 bit.
- Decode (combinational from the counters):
  - active = (h_cnt < H_ACTIVE) && (v_cnt < V_ACTIVE).
  - hsync is asserted for h_cnt in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC).
  - vsync is asserted for v_cnt in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC), for the whole line, aligned to h_cnt = 0.
- Latency: every output is registered exactly one cycle after the counter state it describes. On the first clk_low edge after reset deasserts, the outputs show pixel (0,0): de = 1, frame_start = 1.
- pattern_sel handling:
  - Sampled into an internal register only when h_cnt = 0 and v_cnt = 0.
  - A mid-frame change takes effect at the next frame, so no frame ever mixes patterns.
- Pattern 1, colour bars:
  - BAR_W = H_ACTIVE/8, integer.
  - A bar index counter resets at h_cnt = 0 and advances every BAR_W active pixels. No divider.
  - Order: white FFFFFF, yellow FFFF00, cyan 00FFFF, green 00FF00, magenta FF00FF, red FF0000, blue 0000FF, black 000000.
  - Any remainder columns beyond 8*BAR_W stay black.
- Pattern 2, grid: white when x[4:0] == 0 or y[4:0] == 0, otherwise black.
- Pattern 3, gradient: red = x[7:0], green = y[7:0], blue = x[7:0] ^ y[7:0].
- Pattern 0: all colour channels 0.
- When de = 0: red = green = blue = 0 and x = y = 0, regardless of pattern.
- Reset mid-frame: all outputs go immediately (asynchronously) to their reset values, and the raster restarts at (0,0) after release.

Optional Feature:
- Macro: PATTERN_SCROLL_EN
- Defined:
  - An 8-bit frame counter increments on every frame_start. Reset value 0; wraps 255 -> 0.
  - Colour bars shift left by one pixel per frame: the bar index is computed from (x + frame_cnt) mod H_ACTIVE.
  - Gradient blue becomes x[7:0] ^ y[7:0] ^ frame_cnt.
- Not defined: the counter logic is absent and all patterns are static exactly as in Behaviour.

Test Plan:
- Reset, then run 2 frames with default parameters:
  - hsync is low for exactly 96 cycles per 800-cycle line.
  - de is high for 640 cycles per line.
  - vsync is low for exactly 2 lines per 525-line frame.
  - frame_start pulses every 420000 cycles.
- pattern_sel = 1:
  - Pixels x = 0, 79, 80, 559, 560, 639 on line 10 read FFFFFF, FFFFFF, FFFF00, 0000FF, 000000, 000000.
  - de = 0 during blanking with RGB = 0.
- pattern_sel = 3:
  - Pixel (5,3) reads red = 05, green = 03, blue = 06.
  - Pixel (300,200) reads red = 2C, green = C8, blue = E4.
- Change pattern_sel from 1 to 2 at line 100 of frame 0:
  - The remainder of frame 0 keeps colour bars.
  - Frame 1 pixel (32,0) is white and pixel (33,1) is black.
- Assert reset at h_cnt = 300, v_cnt = 200:
  - Outputs drop to reset values in the same cycle without waiting for a clock edge.
  - After release, the first output is (0,0) with frame_start = 1.
- With PATTERN_SCROLL_EN defined and pattern_sel = 1:
  - In frame 1, pixel x = 79 is yellow (bar boundary shifted by 1).
  - The frame counter wraps from 255 to 0 at frame 256.
